bfly_ejector: RTL
=================

BFLY_EJECTOR -- requirements
Module: bfly_ejector

Interface
REQ-001 SHALL have parameter NPORTS, default 16, the number of net output ports (power of 2, 2..16).
REQ-002 SHALL have parameter DEPTH, default 4, the entries per port FIFO (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state is rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port packet_in  input  NPORTS x 40  the butterfly-net outputs, indexed by port.
REQ-006 SHALL have port out_valid  output  1  meaning the output word is valid.
REQ-007 SHALL have port out_ready  input  1  meaning the consumer accepts the word when out_valid is high.
REQ-008 SHALL have port out_port  output  4  the source port index of the output word.
REQ-009 SHALL have port out_payload  output  32  the packet payload.
REQ-010 SHALL have port drop_cnt  output  16  the saturating count of packets dropped because their FIFO was full.
REQ-011 SHALL have port misroute_err  output  1  a sticky flag set on a misrouted packet.

Function
REQ-012 SHALL use this packet format: bit 39 valid; bits 38:36 reserved; bits 35:32 destination; bits 31:0 payload; an all-zero word means empty.
REQ-013 SHALL, on each rising edge, push the payload of every port p whose packet_in[p] bit 39 is 1 into FIFO p.
REQ-014 SHALL ignore words whose bit 39 is 0, even when other bits are nonzero.
REQ-015 SHALL drop a push to a full FIFO, except that a pop of that FIFO in the same cycle lets the push proceed.
REQ-016 SHALL add the number of drops in a cycle (0..NPORTS) to drop_cnt in that cycle, saturating at 0xFFFF.
REQ-017 SHALL hold out_valid, out_port and out_payload in registers.
REQ-018 SHALL load the output register when (!out_valid || out_ready) and at least one FIFO is non-empty, popping the granted FIFO.
REQ-019 SHALL grant round-robin: the lowest non-empty index at or above rr_ptr, wrapping modulo NPORTS.
REQ-020 SHALL set rr_ptr to (grant+1) mod NPORTS after each load.
REQ-021 SHALL clear out_valid on an out_ready handshake when no FIFO is non-empty.
REQ-022 SHALL hold out_port and out_payload stable while out_valid && !out_ready.
REQ-023 SHALL have a latency of 2 cycles: a packet sampled at edge N with all FIFOs empty and the output idle gives out_valid=1 after edge N+1.
REQ-024 SHALL, when the output is stalled, sustain throughput of 1 word per cycle.
REQ-025 SHALL, in each FIFO, wrap its pointers modulo DEPTH and track occupancy 0..DEPTH, with full at DEPTH and empty at 0.
REQ-026 SHALL never assert backpressure toward the net; loss is visible only through drop_cnt.

Reset
REQ-027 SHALL, with rst_n low, clear all FIFOs, set rr_ptr=0, out_valid=0, out_port=0, out_payload=0, drop_cnt=0 and misroute_err=0.
REQ-028 SHALL, on reset asserted mid-transfer, discard the held word and all FIFO contents, with no partial handshake.
REQ-029 SHALL sample input pushes from the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with macro BFLY_MISROUTE_CHECK_EN defined, discard (not push) any valid packet on port p whose destination != p, and set misroute_err until reset.
REQ-031 SHALL not count a misroute discard in drop_cnt.
REQ-032 SHALL, with BFLY_MISROUTE_CHECK_EN undefined, ignore the destination field, push every valid packet, and tie misroute_err to 0.

Structure
REQ-033 SHALL place in shared package bfly_pkg: PKT_W=40, VALID_BIT=39, DEST_MSB=35, DEST_LSB=32, PAYLOAD_W=32, and the typedef bfly_pkt_t.
REQ-034 SHALL implement each per-port FIFO as the sub-module bfly_eject_fifo (parameter DEPTH, 32-bit data, push/pop/full/empty), instantiated NPORTS times.
REQ-035 SHALL implement the round-robin arbiter, output register and counters in bfly_ejector itself.

Verification
REQ-036 SHALL cover single packet 0x8_3_DEADBEEF on port 3 with out_ready=1 -> out_valid after edge N+1, out_port=3, out_payload=0xDEADBEEF, for 1 cycle.
REQ-037 SHALL cover valid packets on ports 0, 5 and 15 in one cycle with out_ready=1 -> outputs in order 0, 5, 15 on consecutive cycles; rr_ptr ends at 0.
REQ-038 SHALL cover out_ready=0 with 6 packets into port 2 at DEPTH=4 -> 1 word held in the output register, 4 in the FIFO, drop_cnt=1, and out_payload stable throughout.
REQ-039 SHALL cover drop_cnt preloaded to 0xFFFE, then 16 simultaneous drops -> drop_cnt=0xFFFF, with no wrap.
REQ-040 SHALL cover, with the macro defined, packet destination=7 on port 4 -> no output, misroute_err=1, drop_cnt unchanged; with the macro undefined, the payload is output with out_port=4.
REQ-041 SHALL cover rst_n pulsed low while out_valid=1 and FIFOs are non-empty -> all outputs 0 immediately, and no stale words after release.

Source files
------------

// File: rtl/bfly_pkg.sv
// Shared packet format and helpers for the butterfly-network ejector.
package bfly_pkg;

    localparam int PKT_W     = 40;
    localparam int VALID_BIT = 39;
    localparam int DEST_MSB  = 35;
    localparam int DEST_LSB  = 32;
    localparam int PAYLOAD_W = 32;
    localparam int DEST_W    = DEST_MSB - DEST_LSB + 1;
    localparam int DROP_W    = 16;

    typedef struct packed {
        logic                 valid;
        logic [2:0]           rsvd;
        logic [DEST_W-1:0]    dest;
        logic [PAYLOAD_W-1:0] payload;
    } bfly_pkt_t;

    // Add a per-cycle increment to a counter, clamping at all-ones instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [DROP_W-1:0] b);
        logic [DROP_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/bfly_eject_fifo.sv
// Per-port ejection FIFO; a push into a full FIFO succeeds only if it is popped in the same cycle.
module bfly_eject_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their natural width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bfly_ejector.sv
// Butterfly-network ejector: per-port FIFOs drained round-robin into one registered output.
// Build option BFLY_MISROUTE_CHECK_EN discards packets whose destination differs from their port.
module bfly_ejector
    import bfly_pkg::*;
#(
    parameter int NPORTS = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  bfly_pkt_t [NPORTS-1:0]     packet_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_port,
    output logic [PAYLOAD_W-1:0]       out_payload,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic                       misroute_err
);

    localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [NPORTS-1:0]    push;
    logic [NPORTS-1:0]    pop;
    logic [NPORTS-1:0]    full;
    logic [NPORTS-1:0]    empty;
    logic [NPORTS-1:0]    drop;
    logic [NPORTS-1:0]    misroute;
    logic [NPORTS-1:0]    unused_fields;
    logic [PAYLOAD_W-1:0] fifo_dout [NPORTS];

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     rr_idx;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_found;
    logic                 load;
    logic [DROP_W-1:0]    ndrops;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
`ifdef BFLY_MISROUTE_CHECK_EN
        assign misroute[p] = packet_in[p][VALID_BIT] &&
                             (packet_in[p][DEST_MSB:DEST_LSB] != DEST_W'(p));
`else
        assign misroute[p] = 1'b0;
`endif
        assign push[p] = packet_in[p][VALID_BIT] && !misroute[p];
        assign pop[p]  = load && (grant_idx == PTR_W'(p));
        // A pop in the same cycle frees the slot, so only an unpopped full FIFO drops.
        assign drop[p] = push[p] && full[p] && !pop[p];
        assign unused_fields[p] = ^{packet_in[p].rsvd, packet_in[p].dest};

        bfly_eject_fifo #(
            .DEPTH  (DEPTH),
            .DATA_W (PAYLOAD_W)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[p]),
            .pop   (pop[p]),
            .din   (packet_in[p][PAYLOAD_W-1:0]),
            .dout  (fifo_dout[p]),
            .full  (full[p]),
            .empty (empty[p])
        );
    end

    // Search starts at rr_ptr and wraps; NPORTS is a power of two so truncation is the modulo.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_idx      = rr_ptr;
        for (int i = 0; i < NPORTS; i++) begin
            rr_idx = rr_ptr + PTR_W'(i);
            if (!grant_found && !empty[rr_idx]) begin
                grant_found = 1'b1;
                grant_idx   = rr_idx;
            end
        end
    end

    assign load = grant_found && (!out_valid || out_ready);

    always_comb begin
        ndrops = '0;
        for (int i = 0; i < NPORTS; i++) begin
            ndrops = ndrops + DROP_W'(drop[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_port    <= '0;
            out_payload <= '0;
            rr_ptr      <= '0;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_port    <= 4'(grant_idx);
            out_payload <= fifo_dout[grant_idx];
            rr_ptr      <= grant_idx + PTR_W'(1);
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= sat_add(drop_cnt, ndrops);
        end
    end

`ifdef BFLY_MISROUTE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misroute_err <= 1'b0;
        end else if (|misroute) begin
            misroute_err <= 1'b1;
        end
    end
`else
    assign misroute_err = 1'b0;
`endif

endmodule
